// File: rtl/strassen_combine_if.sv
// Product-in / result-out handshake bundle for the Strassen combine stage.
// The block sits on the slave side; the producer/consumer sits on the master side.
interface strassen_combine_if #(
  parameter int BLOCKSIZE = 32,
  parameter int DATAWIDTH = 128
);
  logic [BLOCKSIZE-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [2:0]           m_idx;
  logic [DATAWIDTH-1:0] c_data;
  logic                 c_valid;
  logic                 c_ready;

  modport slave (
    input  m_data, m_valid, c_ready,
    output m_ready, m_idx, c_data, c_valid
  );

  modport master (
    output m_data, m_valid, c_ready,
    input  m_ready, m_idx, c_data, c_valid
  );
endinterface

// File: rtl/strassen_combine.sv
// Strassen post-combination: folds the serial products M1..M7 into C11..C22
// and holds the packed result until downstream takes it.
module strassen_combine #(
  parameter int DATAWIDTH = 128,
  parameter int BLOCKSIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  strassen_combine_if.slave     bus
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [BLOCKSIZE-1:0] c11_q, c11_d;
  logic [BLOCKSIZE-1:0] c12_q, c12_d;
  logic [BLOCKSIZE-1:0] c21_q, c21_d;
  logic [BLOCKSIZE-1:0] c22_q, c22_d;
  logic [DATAWIDTH-1:0] result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      c11_q   <= '0;
      c12_q   <= '0;
      c21_q   <= '0;
      c22_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c11_q   <= c11_d;
      c12_q   <= c12_d;
      c21_q   <= c21_d;
      c22_q   <= c22_d;
    end
  end

  // Each beat index selects which blocks absorb the product and with which sign.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c11_d   = c11_q;
    c12_d   = c12_q;
    c21_d   = c21_q;
    c22_d   = c22_q;
    unique case (state_q)
      ACCUM: begin
        if (bus.m_valid) begin
          case (cnt_q)
            3'd0: begin
              c11_d = c11_q + bus.m_data;
              c22_d = c22_q + bus.m_data;
            end
            3'd1: begin
              c21_d = c21_q + bus.m_data;
              c22_d = c22_q - bus.m_data;
            end
            3'd2: begin
              c12_d = c12_q + bus.m_data;
              c22_d = c22_q + bus.m_data;
            end
            3'd3: begin
              c11_d = c11_q + bus.m_data;
              c21_d = c21_q + bus.m_data;
            end
            3'd4: begin
              c11_d = c11_q - bus.m_data;
              c12_d = c12_q + bus.m_data;
            end
            3'd5: c22_d = c22_q + bus.m_data;
            3'd6: c11_d = c11_q + bus.m_data;
            default: ;
          endcase
          if (cnt_q == 3'd6) begin
            cnt_d   = 3'd0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DONE: begin
        if (bus.c_ready) begin
          c11_d   = '0;
          c12_d   = '0;
          c21_d   = '0;
          c22_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // All handshake outputs come from registers only, so no valid->ready loop exists.
  assign result      = {c22_q, c21_q, c12_q, c11_q};
  assign bus.c_data  = result;
  assign bus.c_valid = (state_q == DONE);
  assign bus.m_ready = (state_q == ACCUM);
  assign bus.m_idx   = cnt_q;

endmodule

// File: tb/tb_strassen_combine.sv
// Self-checking bench for strassen_combine; expected results come from the
// Strassen block formulas applied to the product words.
module tb_strassen_combine;

  localparam int BS = 32;
  localparam int DW = 128;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  strassen_combine_if #(.BLOCKSIZE(BS), .DATAWIDTH(DW)) bus ();

  strassen_combine #(.DATAWIDTH(DW), .BLOCKSIZE(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // C11 = M1+M4-M5+M7, C12 = M3+M5, C21 = M2+M4, C22 = M1-M2+M3+M6
  function automatic logic [DW-1:0] model(input logic [BS-1:0] m [7]);
    logic [BS-1:0] c11, c12, c21, c22;
    c11 = m[0] + m[3] - m[4] + m[6];
    c12 = m[2] + m[4];
    c21 = m[1] + m[3];
    c22 = m[0] - m[1] + m[2] + m[5];
    return {c22, c21, c12, c11};
  endfunction

  // Present one beat and let one rising edge accept it; called only in ACCUM.
  task automatic drive_beat(input logic [BS-1:0] d);
    bus.m_valid = 1'b1;
    bus.m_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    bus.c_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.c_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.m_valid = 1'b0;
    bus.m_data  = '0;
    bus.c_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.c_valid !== 1'b0 || bus.c_data !== '0 || bus.m_idx !== 3'd0 || bus.m_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got c_valid=%b c_data=%h m_idx=%0d m_ready=%b, expected 0/0/0/1",
               bus.c_valid, bus.c_data, bus.m_idx, bus.m_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_known_product();
    logic [BS-1:0] m [7];
    m = '{32'd65, 32'd35, 32'hFFFFFFFE, 32'd8, 32'd24, 32'd22, 32'hFFFFFFE2};
    for (int i = 0; i < 7; i++) drive_beat(m[i]);
    bus.m_valid = 1'b0;
    vectors++;
    if (bus.c_valid !== 1'b1 || bus.c_data !== 128'h00000032_0000002B_00000016_00000013) begin
      miscompares++;
      $display("[TB] FAIL known_product: got c_valid=%b c_data=%h, expected 1 / %h",
               bus.c_valid, bus.c_data, 128'h00000032_0000002B_00000016_00000013);
    end
    handshake();
  endtask

  task automatic test_gaps();
    for (int k = 1; k <= 7; k++) begin
      drive_beat(BS'(k));
      if (k == 2 || k == 5) begin
        bus.m_valid = 1'b0;
        bus.m_data  = 32'h55AA55AA;
        for (int g = 0; g < 2; g++) begin
          @(posedge clk);
          #1;
          vectors++;
          if (bus.m_idx !== 3'(k)) begin
            miscompares++;
            $display("[TB] FAIL gap_hold_idx: got m_idx=%0d, expected %0d", bus.m_idx, k);
          end
        end
      end
    end
    bus.m_valid = 1'b0;
    vectors++;
    if (bus.c_valid !== 1'b1 || bus.c_data !== 128'h00000008_00000006_00000008_00000007) begin
      miscompares++;
      $display("[TB] FAIL gaps_result: got c_valid=%b c_data=%h, expected 1 / %h",
               bus.c_valid, bus.c_data, 128'h00000008_00000006_00000008_00000007);
    end
    handshake();
  endtask

  task automatic test_wrap();
    for (int k = 1; k <= 7; k++) drive_beat((k == 5) ? 32'd1 : 32'd0);
    bus.m_valid = 1'b0;
    vectors++;
    if (bus.c_data !== 128'h00000000_00000000_00000001_FFFFFFFF) begin
      miscompares++;
      $display("[TB] FAIL wrap_result: got c_data=%h, expected %h",
               bus.c_data, 128'h00000000_00000000_00000001_FFFFFFFF);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [BS-1:0] m [7];
    logic [DW-1:0] exp;
    for (int i = 0; i < 7; i++) m[i] = $urandom;
    exp = model(m);
    for (int i = 0; i < 7; i++) drive_beat(m[i]);
    bus.m_valid = 1'b1;
    bus.m_data  = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (bus.c_valid !== 1'b1 || bus.c_data !== exp || bus.m_ready !== 1'b0 || bus.m_idx !== 3'd0) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold: got c_valid=%b c_data=%h m_ready=%b m_idx=%0d, expected 1/%h/0/0",
                 bus.c_valid, bus.c_data, bus.m_ready, bus.m_idx, exp);
      end
      @(posedge clk);
      #1;
    end
    handshake();
    bus.m_valid = 1'b0;
    vectors++;
    if (bus.c_valid !== 1'b0 || bus.m_idx !== 3'd0 || bus.c_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_release: got c_valid=%b m_idx=%0d c_data=%h, expected 0/0/0",
               bus.c_valid, bus.m_idx, bus.c_data);
    end
    for (int k = 1; k <= 7; k++) drive_beat(BS'(k));
    bus.m_valid = 1'b0;
    vectors++;
    if (bus.c_data !== 128'h00000008_00000006_00000008_00000007) begin
      miscompares++;
      $display("[TB] FAIL backpressure_next: got c_data=%h, expected %h",
               bus.c_data, 128'h00000008_00000006_00000008_00000007);
    end
    handshake();
  endtask

  task automatic test_reset_midblock();
    for (int k = 0; k < 4; k++) drive_beat($urandom);
    bus.m_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.c_valid !== 1'b0 || bus.c_data !== '0 || bus.m_idx !== 3'd0 || bus.m_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midblock_reset_state: got c_valid=%b c_data=%h m_idx=%0d m_ready=%b, expected 0/0/0/1",
               bus.c_valid, bus.c_data, bus.m_idx, bus.m_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 7; k++) drive_beat(BS'(k));
    bus.m_valid = 1'b0;
    vectors++;
    if (bus.c_data !== 128'h00000008_00000006_00000008_00000007) begin
      miscompares++;
      $display("[TB] FAIL midblock_reset_result: got c_data=%h, expected %h",
               bus.c_data, 128'h00000008_00000006_00000008_00000007);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [BS-1:0] a [7];
    logic [BS-1:0] b [7];
    logic [DW-1:0] expA, expB;
    for (int i = 0; i < 7; i++) begin
      a[i] = $urandom;
      b[i] = $urandom;
    end
    expA = model(a);
    expB = model(b);
    bus.c_ready = 1'b1;
    for (int i = 0; i < 7; i++) drive_beat(a[i]);
    vectors++;
    if (bus.c_valid !== 1'b1 || bus.c_data !== expA) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got c_valid=%b c_data=%h, expected 1 / %h", bus.c_valid, bus.c_data, expA);
    end
    bus.m_valid = 1'b1;
    bus.m_data  = b[0];
    @(posedge clk);
    #1;
    vectors++;
    if (bus.m_ready !== 1'b1 || bus.m_idx !== 3'd0 || bus.c_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_handshake: got m_ready=%b m_idx=%0d c_valid=%b, expected 1/0/0",
               bus.m_ready, bus.m_idx, bus.c_valid);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.m_idx !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_accept: got m_idx=%0d, expected 1", bus.m_idx);
    end
    for (int i = 1; i < 7; i++) drive_beat(b[i]);
    bus.m_valid = 1'b0;
    vectors++;
    if (bus.c_valid !== 1'b1 || bus.c_data !== expB) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got c_valid=%b c_data=%h, expected 1 / %h", bus.c_valid, bus.c_data, expB);
    end
    @(posedge clk);
    #1;
    bus.c_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [BS-1:0] m [7];
    logic [DW-1:0] exp;
    int            gap;
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 7; i++) m[i] = $urandom;
      exp = model(m);
      for (int i = 0; i < 7; i++) begin
        gap = $urandom_range(0, 2);
        bus.m_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        vectors++;
        if (bus.m_idx !== 3'(i) || bus.m_ready !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL random_idx: got m_idx=%0d m_ready=%b, expected %0d/1", bus.m_idx, bus.m_ready, i);
        end
        drive_beat(m[i]);
      end
      bus.m_valid = $urandom_range(0, 1);
      bus.m_data  = $urandom;
      gap = $urandom_range(0, 3);
      for (int c = 0; c <= gap; c++) begin
        vectors++;
        if (bus.c_valid !== 1'b1 || bus.c_data !== exp) begin
          miscompares++;
          $display("[TB] FAIL random_result: got c_valid=%b c_data=%h, expected 1 / %h", bus.c_valid, bus.c_data, exp);
        end
        if (c < gap) begin
          @(posedge clk);
          #1;
        end
      end
      handshake();
      bus.m_valid = 1'b0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_known_product();
    test_gaps();
    test_wrap();
    test_backpressure();
    test_reset_midblock();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/strassen_combine.md
# strassen_combine

Sequential Strassen post-combination stage for a 2x2 block matrix multiply. It accepts the seven Strassen products M1..M7 as a serial valid/ready stream, one BLOCKSIZE-wide word per beat. It accumulates them into the four result blocks C11, C12, C21 and C22, then presents the packed result on a held valid/ready output. It sits downstream of the pre-addition stage and block multipliers, and consumes products in the same T0..T6 order that the pre-addition stage produces.

## Interface
- DATAWIDTH, default 128: packed output width; must equal 4*BLOCKSIZE.
- BLOCKSIZE, default 32: width of one product word and one result block.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- m_data  input  BLOCKSIZE  product word Mk, where k = beat index + 1.
- m_valid  input  1  m_data is valid.
- m_ready  output  1  block can accept a beat; high exactly when state is ACCUM.
- m_idx  output  3  index (0..6) of the next beat to be accepted.
- c_data  output  DATAWIDTH  packed result {C22, C21, C12, C11}; C11 is in bits [BLOCKSIZE-1:0].
- c_valid  output  1  c_data holds a complete result.
- c_ready  input  1  downstream accepts c_data.

## Operation
- States:
  - ACCUM: collecting beats 0..6.
  - DONE: result held.
- A beat is accepted when m_valid && m_ready.
- Per accepted beat, the accumulators update by the following signs. All other accumulators hold.
  - M1: C11 +, C22 +
  - M2: C21 +, C22 -
  - M3: C12 +, C22 +
  - M4: C11 +, C21 +
  - M5: C11 -, C12 +
  - M6: C22 +
  - M7: C11 +
- Arithmetic is two's-complement modulo 2^BLOCKSIZE: no saturation, no overflow flag, carries discarded.
- Beat counter, driven out on m_idx:
  - Increments on each accepted beat.
  - On the beat with m_idx==6, the counter returns to 0 and the state moves to DONE.
- Gaps (m_valid low) are allowed anywhere in a block. The counter and accumulators hold during a gap.
- DONE:
  - m_ready is 0; m_valid is ignored.
  - c_valid is 1 and c_data is stable.
  - On c_valid && c_ready, the accumulators clear to 0 and the state returns to ACCUM.
- c_data is driven directly from the four accumulator registers.
- There is no mid-block abort other than rst.

## Timing
- Reset values, applied asynchronously while rst is high:
  - State is ACCUM, counter is 0, all accumulators are 0.
  - Outputs: c_valid=0, c_data=0, m_idx=0, m_ready=1.
- Latency: c_valid rises on the clock edge that accepts the 7th beat, so it is visible in the following cycle.
- Minimum period per block is 8 cycles: 7 accept cycles plus 1 DONE cycle with c_ready high.
- m_ready is low in DONE, so no new beat is accepted in the c_ready handshake cycle. The first beat of the next block is accepted, at the earliest, in the cycle after the handshake.
- If c_ready is already high when DONE is entered, the handshake completes in the first DONE cycle.
- c_data and c_valid must not change while c_valid && !c_ready.
- Reset mid-block (rst after k<7 beats) discards the partial sums. The next block starts at m_idx=0 with all accumulators zero.
- m_ready and m_idx are decoded from registered state only; they have no combinational path from m_valid or c_ready.

## Test plan
- Stimulus: known 2x2 product A=[[1,2],[3,4]], B=[[5,6],[7,8]], fed as M=65, 35, 0xFFFFFFFE, 8, 24, 22, 0xFFFFFFE2 with m_valid continuously high.
  - Required: C11=19, C12=22, C21=43, C22=50.
  - Required: c_valid in the cycle after beat 7, with c_data=0x00000032_0000002B_00000016_00000013.
- Stimulus: M1..M7 = 1..7, with 2-cycle m_valid gaps after beats 2 and 5.
  - Required: c_data=0x00000008_00000006_00000008_00000007.
  - Required: m_idx holds its value across each gap.
- Stimulus: wrap-around, with M5=1 and all other M=0.
  - Required: C11=0xFFFFFFFF, C12=1, C21=0, C22=0.
- Stimulus: backpressure, with c_ready low for 3 cycles after c_valid while m_valid is held high with 0xDEADBEEF.
  - Required: c_data is stable and m_ready=0 throughout.
  - Required: after the handshake, the next block's result is unaffected by 0xDEADBEEF.
- Stimulus: rst pulsed asynchronously (mid-cycle) after 4 beats, then a full block of M1..M7 = 1..7.
  - Required: all outputs reach their reset values while rst is high.
  - Required: the result is 0x00000008_00000006_00000008_00000007.
- Stimulus: two back-to-back blocks with c_ready tied high.
  - Required: the second block's first beat is accepted exactly 1 cycle after the first handshake.
  - Required: both results are correct with no carry-over between blocks.
